// File: rtl/freq_detect_pkg.sv
// ------------------------------------------------------------------------
// freq_detect_pkg : mode encodings, classification thresholds, half counts
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package freq_detect_pkg;

  typedef enum logic [2:0] {
    MODE_1K   = 3'd0,
    MODE_5K   = 3'd1,
    MODE_10K  = 3'd2,
    MODE_50K  = 3'd3,
    MODE_100K = 3'd4,
    MODE_500K = 3'd5,
    MODE_1M   = 3'd6,
    MODE_2M   = 3'd7
  } mode_e;

  typedef enum logic [0:0] {
    S_WAIT_FIRST = 1'b0,
    S_MEASURE    = 1'b1
  } state_e;

  // Lower period bound (clk cycles) of each mode; below c_thr_2m is out of range.
  localparam int unsigned c_thr_1k   = 20000;
  localparam int unsigned c_thr_5k   = 7000;
  localparam int unsigned c_thr_10k  = 2200;
  localparam int unsigned c_thr_50k  = 700;
  localparam int unsigned c_thr_100k = 220;
  localparam int unsigned c_thr_500k = 70;
  localparam int unsigned c_thr_1m   = 35;
  localparam int unsigned c_thr_2m   = 12;

  // Nominal half-period counts used by the mode-to-count selector.
  localparam int unsigned c_half_1k   = 25000;
  localparam int unsigned c_half_5k   = 5000;
  localparam int unsigned c_half_10k  = 2500;
  localparam int unsigned c_half_50k  = 500;
  localparam int unsigned c_half_100k = 250;
  localparam int unsigned c_half_500k = 50;
  localparam int unsigned c_half_1m   = 25;
  localparam int unsigned c_half_2m   = 12;

endpackage : freq_detect_pkg

`default_nettype wire

// File: rtl/freq_detect_period2mode.sv
// ------------------------------------------------------------------------
// period2mode : combinational period-to-mode classifier with range flag
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module period2mode
  import freq_detect_pkg::*;
#(
  parameter int CNT_W = 28
) (
  input  logic [CNT_W-1:0] i_period,
  output logic [2:0]       o_mode,
  output logic             o_in_range
);

  logic [63:0] w_p;

  assign w_p = 64'(i_period);

  always_comb begin
    o_mode     = MODE_1K;
    o_in_range = 1'b1;
    if (w_p >= 64'(c_thr_1k))        o_mode = MODE_1K;
    else if (w_p >= 64'(c_thr_5k))   o_mode = MODE_5K;
    else if (w_p >= 64'(c_thr_10k))  o_mode = MODE_10K;
    else if (w_p >= 64'(c_thr_50k))  o_mode = MODE_50K;
    else if (w_p >= 64'(c_thr_100k)) o_mode = MODE_100K;
    else if (w_p >= 64'(c_thr_500k)) o_mode = MODE_500K;
    else if (w_p >= 64'(c_thr_1m))   o_mode = MODE_1M;
    else if (w_p >= 64'(c_thr_2m))   o_mode = MODE_2M;
    else                             o_in_range = 1'b0;
  end

endmodule : period2mode

`default_nettype wire

// File: rtl/freq_detect.sv
// ------------------------------------------------------------------------
// freq_detect : square-wave period meter reporting period, mode and lock
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module freq_detect
  import freq_detect_pkg::*;
#(
  parameter int CNT_W    = 28,
  parameter int TIMEOUT  = 131072,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sig_in,
  output logic [CNT_W-1:0] o_period,
  output logic [2:0]       o_mode,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_meas_stb
);

  localparam logic [3:0] c_lock = 4'(LOCK_CNT);

  logic [1:0]       r_sync;
  logic             r_sync_d;
  logic             r_edge;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [2:0]       r_mode;
  logic             r_valid;
  logic             r_locked;
  logic             r_stb;
  logic [3:0]       r_match;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [2:0]       w_mode_nxt;
  logic             w_valid_nxt;
  logic             w_locked_nxt;
  logic             w_stb_nxt;
  logic [3:0]       w_match_nxt;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_p;
  logic [2:0]       w_cls;
  logic             w_in_range;
  logic             w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b00;
      r_sync_d <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], i_sig_in};
      r_sync_d <= r_sync[1];
      r_edge   <= r_sync[1] & ~r_sync_d;
    end
  end

  // A saturated count stays at all-ones rather than wrapping, so it classifies as the slowest mode.
  assign w_cnt_sat = &r_cnt;
  assign w_p       = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout = (64'(r_cnt) == 64'(TIMEOUT - 1));

  period2mode #(
    .CNT_W (CNT_W)
  ) u_period2mode (
    .i_period   (w_p),
    .o_mode     (w_cls),
    .o_in_range (w_in_range)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_mode_nxt   = r_mode;
    w_valid_nxt  = r_valid;
    w_locked_nxt = r_locked;
    w_match_nxt  = r_match;
    w_stb_nxt    = 1'b0;
    case (r_state)
      S_WAIT_FIRST: begin
        w_cnt_nxt = '0;
        if (r_edge) w_state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (r_edge) begin
          w_cnt_nxt    = '0;
          w_period_nxt = w_p;
          w_stb_nxt    = 1'b1;
          if (!w_in_range) begin
            w_valid_nxt  = 1'b0;
            w_match_nxt  = 4'd0;
            w_locked_nxt = 1'b0;
          end else begin
            w_valid_nxt = 1'b1;
            w_mode_nxt  = w_cls;
            if (w_cls == r_mode)
              w_match_nxt = (r_match >= c_lock) ? c_lock : r_match + 4'd1;
            else
              w_match_nxt = 4'd1;
            w_locked_nxt = (w_match_nxt == c_lock);
          end
        end else if (w_timeout) begin
          w_state_nxt  = S_WAIT_FIRST;
          w_cnt_nxt    = '0;
          w_period_nxt = '0;
          w_valid_nxt  = 1'b0;
          w_locked_nxt = 1'b0;
          w_match_nxt  = 4'd0;
        end else if (!w_cnt_sat) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_WAIT_FIRST;
      r_cnt    <= '0;
      r_period <= '0;
      r_mode   <= 3'd0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_stb    <= 1'b0;
      r_match  <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_mode   <= w_mode_nxt;
      r_valid  <= w_valid_nxt;
      r_locked <= w_locked_nxt;
      r_stb    <= w_stb_nxt;
      r_match  <= w_match_nxt;
    end
  end

  assign o_period   = r_period;
  assign o_mode     = r_mode;
  assign o_valid    = r_valid;
  assign o_locked   = r_locked;
  assign o_meas_stb = r_stb;

endmodule : freq_detect

`default_nettype wire

// File: tb/tb_freq_detect.sv
// ------------------------------------------------------------------------
// tb_freq_detect : directed stimulus with an edge-time model of freq_detect
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_freq_detect;

  localparam int CNT_W    = 28;
  localparam int TIMEOUT  = 20480;
  localparam int LOCK_CNT = 2;
  localparam int LAT      = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [2:0]       mode;
  logic             valid;
  logic             locked;
  logic             meas_stb;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int rises[$];
  int exp_period = 0;
  int exp_mode = 0;
  bit exp_valid = 0;
  bit exp_locked = 0;
  bit exp_stb = 0;
  int match = 0;
  bit have_ref = 0;
  int last_rise = 0;

  int n_stb = 0;
  int snap_period = -1;
  int snap_mode = -1;
  int snap_valid = -1;
  int snap_locked = -1;

  freq_detect #(
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sig_in   (sig_in),
    .o_period   (period),
    .o_mode     (mode),
    .o_valid    (valid),
    .o_locked   (locked),
    .o_meas_stb (meas_stb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int classify(int p);
    int thr[8];
    thr = '{20000, 7000, 2200, 700, 220, 70, 35, 12};
    for (int i = 0; i < 8; i++)
      if (p >= thr[i]) return i;
    return -1;
  endfunction

  task automatic measure(int p);
    int c;
    exp_stb    = 1'b1;
    exp_period = p;
    c = classify(p);
    if (c < 0) begin
      exp_valid  = 1'b0;
      exp_locked = 1'b0;
      match      = 0;
    end else begin
      if (c == exp_mode) match = (match + 1 > LOCK_CNT) ? LOCK_CNT : match + 1;
      else               match = 1;
      exp_mode   = c;
      exp_valid  = 1'b1;
      exp_locked = (match == LOCK_CNT);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      rises.delete();
      have_ref = 0; match = 0;
      exp_period = 0; exp_mode = 0; exp_valid = 0; exp_locked = 0; exp_stb = 0;
      checks++;
      if (period !== '0 || mode !== 3'd0 || valid !== 1'b0 || locked !== 1'b0 || meas_stb !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d actual p=%0d m=%0d v=%0b l=%0b s=%0b required all zero",
                 cyc, period, mode, valid, locked, meas_stb);
      end
    end else begin
      exp_stb = 1'b0;
      if (rises.size() > 0 && rises[0] == cyc - LAT) begin
        int r;
        r = rises.pop_front();
        if (have_ref) measure(r - last_rise);
        have_ref  = 1;
        last_rise = r;
      end else if (have_ref && cyc == last_rise + TIMEOUT + LAT) begin
        have_ref = 0; match = 0;
        exp_period = 0; exp_valid = 0; exp_locked = 0;
      end
      checks++;
      if (int'(period) != exp_period || int'(mode) != exp_mode || valid !== exp_valid ||
          locked !== exp_locked || meas_stb !== exp_stb) begin
        failures++;
        $display("FAIL model cyc=%0d actual p=%0d m=%0d v=%0b l=%0b s=%0b required p=%0d m=%0d v=%0b l=%0b s=%0b",
                 cyc, period, mode, valid, locked, meas_stb,
                 exp_period, exp_mode, exp_valid, exp_locked, exp_stb);
      end
      if (meas_stb === 1'b1) begin
        n_stb++;
        snap_period = int'(period);
        snap_mode   = int'(mode);
        snap_valid  = int'(valid);
        snap_locked = int'(locked);
      end
    end
  end

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic pulse(int p);
    sig_in = 1'b1;
    rises.push_back(cyc);
    repeat (p / 2) @(negedge clk);
    sig_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  // Each call's rise closes the previous gap; its strobe lands inside the pulse.
  task automatic pulse_chk(int p, int e_per, int e_mode, int e_val, int e_lock);
    pulse(p);
    chk($sformatf("per_after_%0d", e_per), snap_period, e_per);
    chk($sformatf("mode_after_%0d", e_per), snap_mode, e_mode);
    chk($sformatf("valid_after_%0d", e_per), snap_valid, e_val);
    chk($sformatf("lock_after_%0d", e_per), snap_locked, e_lock);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_stb"}, int'(meas_stb), 0);
  endtask

  initial begin
    int s0;
    int r;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);

    s0 = n_stb;
    repeat (4) pulse(24);
    chk("p24_strobes", n_stb - s0, 3);
    chk("p24_period", snap_period, 24);
    chk("p24_mode", snap_mode, 7);
    chk("p24_locked", snap_locked, 1);

    pulse_chk(11,    24,    7, 1, 1);
    pulse_chk(12,    11,    7, 0, 0);
    pulse_chk(34,    12,    7, 1, 0);
    pulse_chk(35,    34,    7, 1, 1);
    pulse_chk(8,     35,    6, 1, 0);
    pulse_chk(8,     8,     6, 0, 0);
    pulse_chk(2300,  8,     6, 0, 0);
    pulse_chk(2300,  2300,  2, 1, 0);
    pulse_chk(500,   2300,  2, 1, 1);
    pulse_chk(500,   500,   4, 1, 0);
    pulse_chk(19999, 500,   4, 1, 1);
    pulse_chk(20000, 19999, 1, 1, 0);
    pulse_chk(24,    20000, 0, 1, 0);
    pulse_chk(24,    24,    7, 1, 0);

    sig_in = 1'b1;
    rises.push_back(cyc);
    r = cyc;
    repeat (12) @(negedge clk);
    sig_in = 1'b0;
    while (cyc < r + TIMEOUT + LAT - 1) @(negedge clk);
    chk("pre_to_valid", int'(valid), 1);
    chk("pre_to_locked", int'(locked), 1);
    chk("pre_to_period", int'(period), 24);
    @(negedge clk);
    chk("to_valid", int'(valid), 0);
    chk("to_locked", int'(locked), 0);
    chk("to_period", int'(period), 0);
    chk("to_mode_held", int'(mode), 7);
    chk("to_stb", int'(meas_stb), 0);

    s0 = n_stb;
    pulse(24);
    pulse(24);
    chk("post_to_strobes", n_stb - s0, 1);
    chk("post_to_period", snap_period, 24);
    chk("post_to_locked", snap_locked, 0);

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    s0 = n_stb;
    pulse(24);
    pulse(24);
    chk("post_rst_strobes", n_stb - s0, 1);
    chk("post_rst_period", snap_period, 24);
    chk("post_rst_mode", snap_mode, 7);
    chk("post_rst_locked", snap_locked, 0);

    repeat (30) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_freq_detect

`default_nettype wire
